// File: rtl/exp_set_reg_pkg.sv
// Shared types and default exposure limits for the exposure-setting register.
// Holds the FSM state encoding, the button direction encoding and the saturating step helper.
package exp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam logic [4:0] EXP_MIN_DEF     = 5'd2;
    localparam logic [4:0] EXP_MAX_DEF     = 5'd30;
    localparam logic [4:0] EXP_DEFAULT_DEF = 5'd10;

    // One step in the given direction, pinned to [lo, hi] without wrapping.
    function automatic logic [4:0] sat_step(input logic [4:0] v, input dir_t d,
                                            input logic [4:0] lo, input logic [4:0] hi);
        logic [4:0] r;
        r = v;
        if (d == DIR_UP && v < hi)
            r = v + 5'd1;
        else if (d == DIR_DOWN && v > lo)
            r = v - 5'd1;
        return r;
    endfunction

endpackage

// File: rtl/exp_set_reg_if.sv
// Button/busy/load inputs and countdown-register outputs of the exposure-setting register.
// The slave side is the register itself; the master side is whatever drives the buttons.
interface exp_set_reg_if;
    logic       exp_increase;
    logic       exp_decrease;
    logic       busy;
    logic       load_req;
    logic [4:0] dread_data;
    logic       dset;
    logic       at_max;
    logic       at_min;

    modport slave (
        input  exp_increase, exp_decrease, busy, load_req,
        output dread_data, dset, at_max, at_min
    );

    modport master (
        output exp_increase, exp_decrease, busy, load_req,
        input  dread_data, dset, at_max, at_min
    );
endinterface

// File: rtl/exp_set_reg_rep_timer.sv
// Hold/repeat timer: counts enabled edges from zero and flags when the count reaches limit.
// The owner clears it on every state change and on each terminal count.
module rep_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

    assign tc = (count == limit);

endmodule

// File: rtl/exp_set_reg.sv
// Exposure-setting register: button-driven saturating up/down value with hold-to-repeat,
// plus a one-clock load strobe that transfers the value to the countdown register.
//
//   state  | meaning
//   IDLE   | no direction held (or just interrupted); next active edge is a first press
//   HOLD   | first step taken, waiting out the initial repeat delay
//   REPEAT | auto-repeat running, one step per repeat period
module exp_set_reg import exp_pkg::*; #(
    parameter logic [4:0] EXP_MIN      = EXP_MIN_DEF,
    parameter logic [4:0] EXP_MAX      = EXP_MAX_DEF,
    parameter logic [4:0] EXP_DEFAULT  = EXP_DEFAULT_DEF,
    parameter int         REPEAT_DELAY = 8,
    parameter int         REPEAT_RATE  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    exp_set_reg_if.slave bus
);

    localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] LIM_DELAY = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] LIM_RATE  = TW'(REPEAT_RATE - 1);

    state_t        state, state_nxt;
    dir_t          dir, prev_dir, pend_dir;
    logic [4:0]    value;
    logic          dset_r, load_prev, pend;
    logic          step, tmr_clr, tmr_en, tmr_tc, load_rise, held;
    logic [TW-1:0] tmr_limit;

    always_comb begin
        dir = DIR_NONE;
        if (bus.exp_increase && !bus.exp_decrease)
            dir = DIR_UP;
        else if (bus.exp_decrease && !bus.exp_increase)
            dir = DIR_DOWN;
    end

    assign held      = (dir != DIR_NONE) && (dir == prev_dir);
    assign load_rise = bus.load_req && !load_prev;
    assign tmr_limit = (state == HOLD) ? LIM_DELAY : LIM_RATE;

    rep_timer #(.WIDTH(TW)) u_rep_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .tc      (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        if (bus.busy) begin
            state_nxt = IDLE;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tmr_clr = 1'b1;
                    if (dir != DIR_NONE) begin
                        step      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!held) begin
                        state_nxt = IDLE;
                        tmr_clr   = 1'b1;
                    end else if (tmr_tc) begin
                        step      = 1'b1;
                        state_nxt = REPEAT;
                        tmr_clr   = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev_dir  <= DIR_NONE;
            load_prev <= 1'b0;
            dset_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev_dir  <= dir;
            load_prev <= bus.load_req;
            dset_r    <= load_rise;
        end
    end

    // A step landing on the strobe edge is parked so the value is stable while dset is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value    <= EXP_DEFAULT;
            pend     <= 1'b0;
            pend_dir <= DIR_NONE;
        end else if (bus.busy) begin
            pend <= 1'b0;
        end else if (load_rise) begin
            pend     <= step;
            pend_dir <= dir;
        end else begin
            pend <= 1'b0;
            if (step)
                value <= sat_step(value, dir, EXP_MIN, EXP_MAX);
            else if (pend)
                value <= sat_step(value, pend_dir, EXP_MIN, EXP_MAX);
        end
    end

    assign bus.dread_data = value;
    assign bus.dset       = dset_r;
    assign bus.at_max     = (value == EXP_MAX);
    assign bus.at_min     = (value == EXP_MIN);

endmodule

// File: tb/tb_exp_set_reg.sv
// Scoreboard bench for exp_set_reg: directed stimulus queues expected values per cycle,
// a separate monitor pops and compares them against the DUT outputs.
module tb_exp_set_reg;

    localparam logic [4:0] EMIN = 5'd2;
    localparam logic [4:0] EMAX = 5'd30;
    localparam logic [4:0] EDEF = 5'd10;

    typedef struct {
        int         cyc;
        logic [4:0] val;
        logic       dset;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t q[$];
    event chk_ev;

    exp_set_reg_if bus();

    exp_set_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk or chk_ev) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            if ({bus.dread_data, bus.dset, bus.at_max, bus.at_min} ===
                {e.val, e.dset, (e.val == EMAX), (e.val == EMIN)})
                n_pass++;
            else
                $display("FAIL %s cyc=%0d: got data=%0d dset=%0b at_max=%0b at_min=%0b, want data=%0d dset=%0b at_max=%0b at_min=%0b",
                         e.name, cyc, bus.dread_data, bus.dset, bus.at_max, bus.at_min,
                         e.val, e.dset, (e.val == EMAX), (e.val == EMIN));
        end
    end

    // Steps taken after h edges of continuous hold with REPEAT_DELAY=8, REPEAT_RATE=4.
    function automatic int n_steps(input int h);
        if (h < 1) return 0;
        if (h < 9) return 1;
        return 2 + (h - 9) / 4;
    endfunction

    task automatic drive(input logic inc, input logic dec, input logic bsy, input logic ld,
                         input logic [4:0] ev, input logic ed, input string nm);
        bus.exp_increase = inc;
        bus.exp_decrease = dec;
        bus.busy         = bsy;
        bus.load_req     = ld;
        q.push_back('{cyc + 1, ev, ed, nm});
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #1;
        reset_n      = 1'b0;
        bus.load_req = 1'b0;
        #1;
        q.push_back('{cyc, EDEF, 1'b0, nm});
        -> chk_ev;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] v;
        bus.exp_increase = 1'b0;
        bus.exp_decrease = 1'b0;
        bus.busy         = 1'b0;
        bus.load_req     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        q.push_back('{cyc, EDEF, 1'b0, "in_reset"});
        -> chk_ev;
        #1;
        reset_n = 1'b1;

        drive(0, 0, 0, 0, EDEF, 0, "idle_after_reset");
        drive(0, 0, 0, 0, EDEF, 0, "idle_after_reset");

        v = EDEF;
        for (int i = 0; i < 25; i++) begin
            v = (v < EMAX) ? v + 5'd1 : EMAX;
            drive(1, 0, 0, 0, v, 0, "inc_pulse");
            drive(0, 0, 0, 0, v, 0, "inc_gap");
        end

        do_reset("reset_from_max");
        for (int h = 1; h <= 30; h++)
            drive(0, 1, 0, 0, 5'(10 - n_steps(h)), 0, "dec_hold");
        drive(0, 0, 0, 0, 5'd3, 0, "dec_release");

        drive(0, 1, 0, 0, 5'd2, 0, "dec_to_min");
        drive(0, 0, 0, 0, 5'd2, 0, "min_gap");
        drive(0, 1, 0, 0, 5'd2, 0, "dec_sat_min");
        drive(0, 0, 0, 0, 5'd2, 0, "min_gap");

        drive(1, 0, 1, 0, 5'd2, 0, "busy_frozen");
        drive(1, 0, 1, 0, 5'd2, 0, "busy_frozen");
        drive(1, 0, 1, 0, 5'd2, 0, "busy_frozen");
        drive(1, 0, 0, 0, 5'd3, 0, "busy_drop_step");
        drive(1, 0, 0, 0, 5'd3, 0, "busy_drop_hold");
        drive(0, 0, 0, 0, 5'd3, 0, "busy_release");

        drive(1, 0, 0, 0, 5'd4, 0, "chg_up");
        drive(1, 0, 0, 0, 5'd4, 0, "chg_up_hold");
        drive(0, 1, 0, 0, 5'd4, 0, "chg_no_step");
        drive(0, 1, 0, 0, 5'd3, 0, "chg_new_press");
        drive(0, 0, 0, 0, 5'd3, 0, "chg_release");

        drive(1, 0, 0, 1, 5'd3, 1, "load_defer");
        drive(1, 0, 0, 1, 5'd4, 0, "load_apply");
        drive(1, 0, 0, 1, 5'd4, 0, "load_held");
        drive(1, 0, 0, 1, 5'd4, 0, "load_held");
        drive(1, 0, 0, 1, 5'd4, 0, "load_held");
        drive(0, 0, 0, 0, 5'd4, 0, "load_release");
        drive(0, 0, 1, 1, 5'd4, 1, "load_busy");
        drive(0, 0, 1, 1, 5'd4, 0, "load_busy_held");
        drive(0, 0, 0, 0, 5'd4, 0, "load_busy_release");

        do_reset("reset_to_default");
        for (int h = 1; h <= 41; h++)
            drive(1, 0, 0, 0, 5'(10 + n_steps(h)), 0, "inc_to_repeat");
        drive(1, 0, 0, 1, 5'd20, 1, "strobe_in_repeat");
        do_reset("reset_mid_repeat");
        drive(1, 0, 0, 0, 5'd11, 0, "post_reset_press");
        drive(1, 0, 0, 0, 5'd11, 0, "post_reset_hold");
        drive(0, 0, 0, 0, 5'd11, 0, "post_reset_release");

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
